// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_mc
//  Description : Hazard/forwarding controller for a 5-stage pipeline.
//                M/W operand forwarding into E, branch/jump flushes,
//                multi-cycle load-use stalling and a multi-cycle execute
//                (mul/div) hold of the E stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc #(
    parameter int REG_AW  = 5,
    parameter int LD_LAT  = 1,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic [1:0]        PCSrcE,
    input  logic              MulStartE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MulBusy
);

    localparam int LD_CW = $clog2(LD_LAT + 1);
    localparam int MC_CW = $clog2(MUL_LAT + 1);

    localparam logic [0:0] c_LD_IDLE = 1'b0;
    localparam logic [0:0] c_LD_WAIT = 1'b1;
    localparam logic [0:0] c_MC_IDLE = 1'b0;
    localparam logic [0:0] c_MC_BUSY = 1'b1;

    // The first stall cycle is issued from IDLE, so WAIT/BUSY cover the rest.
    localparam logic             c_LD_MULTI  = (LD_LAT > 1);
    localparam logic             c_MUL_MULTI = (MUL_LAT > 1);
    localparam logic [LD_CW-1:0] c_LD_RELOAD = LD_CW'(LD_LAT > 1 ? LD_LAT - 1 : 0);
    localparam logic [MC_CW-1:0] c_MC_RELOAD = MC_CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
    localparam logic [LD_CW-1:0] c_LD_ONE    = LD_CW'(1);

    logic [0:0]       r_ldState;
    logic [0:0]       w_ldStateNext;
    logic [LD_CW-1:0] r_ldCnt;
    logic [LD_CW-1:0] w_ldCntNext;
    logic [0:0]       r_mcState;
    logic [0:0]       w_mcStateNext;
    logic [MC_CW-1:0] r_mcCnt;
    logic [MC_CW-1:0] w_mcCntNext;

    logic w_ldHit;
    logic w_ldStall;
    logic w_mulStall;

    // Stall sources: a load in E feeding D, and a multi-cycle op holding E.
    always_comb begin
        w_ldHit    = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
        w_mulStall = ((r_mcState == c_MC_IDLE) && MulStartE && c_MUL_MULTI) ||
                     ((r_mcState == c_MC_BUSY) && (r_mcCnt != '0));
        // A held E stage masks new load-use detection until the op completes.
        w_ldStall  = ((r_ldState == c_LD_IDLE) && w_ldHit && !w_mulStall) ||
                     (r_ldState == c_LD_WAIT);
    end

    // State and counter registers for both FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ldState <= c_LD_IDLE;
            r_ldCnt   <= '0;
            r_mcState <= c_MC_IDLE;
            r_mcCnt   <= '0;
        end else begin
            r_ldState <= w_ldStateNext;
            r_ldCnt   <= w_ldCntNext;
            r_mcState <= w_mcStateNext;
            r_mcCnt   <= w_mcCntNext;
        end
    end

    // Next-state logic for the load-use and multi-cycle FSMs.
    always_comb begin
        w_ldStateNext = r_ldState;
        w_ldCntNext   = r_ldCnt;
        w_mcStateNext = r_mcState;
        w_mcCntNext   = r_mcCnt;

        case (r_ldState)
            c_LD_IDLE: begin
                if (w_ldHit && !w_mulStall && c_LD_MULTI) begin
                    w_ldStateNext = c_LD_WAIT;
                    w_ldCntNext   = c_LD_RELOAD;
                end
            end
            c_LD_WAIT: begin
                w_ldCntNext = r_ldCnt - 1'b1;
                if (r_ldCnt == c_LD_ONE) begin
                    w_ldStateNext = c_LD_IDLE;
                end
            end
            default: w_ldStateNext = c_LD_IDLE;
        endcase

        // MulStartE is deliberately ignored while BUSY; the same op is still in E.
        case (r_mcState)
            c_MC_IDLE: begin
                if (MulStartE && c_MUL_MULTI) begin
                    w_mcStateNext = c_MC_BUSY;
                    w_mcCntNext   = c_MC_RELOAD;
                end
            end
            c_MC_BUSY: begin
                if (r_mcCnt != '0) begin
                    w_mcCntNext = r_mcCnt - 1'b1;
                end else begin
                    w_mcStateNext = c_MC_IDLE;
                end
            end
            default: w_mcStateNext = c_MC_IDLE;
        endcase
    end

    // Output decode: forwarding muxes, stalls and flushes, all forced low in reset.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        MulBusy   = 1'b0;

        if (!rst) begin
            // M is the younger producer, so it takes priority over W.
            if ((Rs1E == RdM) && RegWriteM && (Rs1E != '0)) begin
                ForwardAE = 2'b10;
            end else if ((Rs1E == RdW) && RegWriteW && (Rs1E != '0)) begin
                ForwardAE = 2'b01;
            end

            if ((Rs2E == RdM) && RegWriteM && (Rs2E != '0)) begin
                ForwardBE = 2'b10;
            end else if ((Rs2E == RdW) && RegWriteW && (Rs2E != '0)) begin
                ForwardBE = 2'b01;
            end

            StallF  = w_ldStall | w_mulStall;
            StallD  = w_ldStall | w_mulStall;
            StallE  = w_mulStall;
            FlushM  = w_mulStall;
            FlushD  = (PCSrcE != 2'b00);
            // E is never flushed while it is being held by the multi-cycle op.
            FlushE  = (w_ldStall | (PCSrcE != 2'b00)) & !w_mulStall;
            MulBusy = (r_mcState == c_MC_BUSY);
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised hazard/forwarding controller for the 5-stage pipelined CPU (F/D/E/M/W).
- Provides M/W operand forwarding into E and branch/jump control-hazard flushes.
- Adds stateful load-use stalling for a data memory with configurable latency.
- Adds a multi-cycle execute FSM (mul/div unit) that holds E for MUL_LAT cycles while bubbling M.

Parameters:
REG_AW, 5, register-address width
LD_LAT, 1, bubbles inserted on a load-use hazard (>=1; 1 = classic single bubble)
MUL_LAT, 4, total cycles a multi-cycle op occupies E (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
Rs1D, Rs2D  in  REG_AW  source regs of instr in D
Rs1E, Rs2E  in  REG_AW  source regs of instr in E
RdE, RdM, RdW  in  REG_AW  dest regs in E/M/W
RegWriteM, RegWriteW  in  1  dest write enables in M/W
ResultSrcE0  in  1  instr in E is a load
PCSrcE  in  2  non-zero = taken branch/jump resolved in E
MulStartE  in  1  instr in E is a multi-cycle op (held high while it sits in E)
StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
FlushD, FlushE, FlushM  out  1  clear IF-ID / ID-EX / EX-MEM registers
ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
MulBusy  out  1  multi-cycle FSM not IDLE

Behaviour:
- Reset: while rst=1, every output is 0 and ForwardAE/BE=00. On the clock edge with rst=1, both FSMs go to IDLE and both counters clear. Reset mid-stall aborts the stall.
- Forwarding is combinational:
  - ForwardAE=10 if Rs1E==RdM, RegWriteM, and Rs1E!=0.
  - Else ForwardAE=01 if Rs1E==RdW, RegWriteW, and Rs1E!=0.
  - Else 00. M wins over W. ForwardBE follows the same rules on Rs2E.
- Load-use detection: ldHit = ResultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE). A load to x0 never stalls.
- Load FSM, states LD_IDLE and LD_WAIT, counter ld_cnt of width clog2(LD_LAT+1):
  - LD_IDLE & ldHit & !mulStall: assert ldStall this cycle. If LD_LAT>1, load ld_cnt=LD_LAT-1 and go to LD_WAIT.
  - LD_WAIT: assert ldStall and decrement ld_cnt. At ld_cnt==1, return to LD_IDLE on the next edge.
  - Net effect: exactly LD_LAT consecutive ldStall cycles per hazard.
- Multi-cycle FSM, states MC_IDLE and MC_BUSY, counter mc_cnt:
  - MC_IDLE & MulStartE & MUL_LAT>1: mulStall=1; mc_cnt=MUL_LAT-2; go to MC_BUSY.
  - MC_BUSY & mc_cnt!=0: mulStall=1; decrement mc_cnt.
  - MC_BUSY & mc_cnt==0: mulStall=0 so the op advances; go to MC_IDLE. MulStartE is ignored in MC_BUSY.
  - MUL_LAT=1: never stalls.
  - Net effect: MUL_LAT-1 stall cycles, so the op spends MUL_LAT cycles in E.
  - MulBusy=1 in MC_BUSY.
- Output equations:
  - StallF = StallD = ldStall | mulStall
  - StallE = mulStall
  - FlushM = mulStall
  - FlushD = (PCSrcE!=00)
  - FlushE = (ldStall | PCSrcE!=00) & !mulStall (E is never flushed while held)
- Simultaneous events:
  - mulStall masks new ldHit detection. An ldHit pending after the mul completes is detected then.
  - A branch in E cannot coexist with mulStall or an E-stage load. If PCSrcE!=0 during LD_WAIT, the flush outputs are still driven per the equations and ld_cnt keeps counting.

Test Plan:
- Forwarding: Rs1E=5, RdM=5 and RegWriteM=1, RdW=5 and RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 with RdM=0, RegWriteM=1 -> 00. Repeat the same cases on Rs2E/ForwardBE.
- Load-use at LD_LAT=1 and LD_LAT=3: ResultSrcE0=1, RdE=7, Rs2D=7 for one cycle, then a bubble in E:
  - StallF/StallD/FlushE high for exactly 1 (resp. 3) cycles, then low.
  - Repeat with RdE=0 -> no stall.
- Multi-cycle op with MUL_LAT=4: MulStartE held high while E is stalled:
  - StallF/D/E and FlushM high for exactly 3 cycles, FlushE=0 throughout.
  - MulBusy high in cycles 2-4; op leaves E after cycle 4.
  - A second back-to-back MulStartE restarts the FSM.
- Branch: PCSrcE=01 for one cycle -> FlushD=FlushE=1 in that cycle only; no stall outputs.
- Mul with pending load-use: mul in E, load in D, consumer in F -> mul stall completes first; ldHit is then detected when the load reaches E, giving LD_LAT bubbles.
- Reset mid-operation: assert rst in the 2nd cycle of a MUL_LAT=4 stall -> all outputs 0 while rst=1. After release, MulBusy=0 and no residual stall; same check during LD_WAIT.
